// File: rtl/sio_rx_fifo.sv
// Receive-side byte FIFO between the serial receiver and the Z80 I/O bus.
// The CPU reads data at cd=0 and status at cd=1; a control write at cd=1 clears overrun or flushes.
`timescale 1ns/1ps
module sio_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ce,
  input  logic       rd,
  input  logic       wr,
  input  logic       cd,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rx_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  rd_data_q;
  logic                  wr_ctl_q;

  logic                  rd_data_sel;
  logic                  rd_stat_sel;
  logic                  wr_ctl_sel;
  logic                  ctl_edge;
  logic                  flush;
  logic                  ovr_clr;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_ok;
  logic                  ovr_set;
  logic [4:0]            count5;
  logic [7:0]            status;

  assign rd_data_sel = ce & rd & ~cd;
  assign rd_stat_sel = ce & rd & cd;
  assign wr_ctl_sel  = ce & wr & cd;
  assign ctl_edge    = wr_ctl_sel & ~wr_ctl_q;
  assign flush       = ctl_edge & data_in[7];
  assign ovr_clr     = ctl_edge & data_in[2];

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // One pop per CPU read, taken when the data-read strobe falls.
  assign pop     = rd_data_q & ~rd_data_sel & ~empty;
  assign push_ok = rx_valid & (~full | pop);
  assign ovr_set = rx_valid & full & ~pop & ~flush;

  if (DEPTH_LOG2 >= 4) begin : g_cnt_trunc
    assign count5 = count[4:0];
  end else begin : g_cnt_ext
    assign count5 = {{(4 - DEPTH_LOG2){1'b0}}, count};
  end

  assign status = {count5, overrun, full, ~empty};

  always_ff @(posedge clk) begin
    if (n_rst && push_ok && !flush) begin
      mem[wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      data_out  <= 8'h00;
      rx_irq    <= 1'b0;
      rd_data_q <= 1'b0;
      wr_ctl_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_sel;
      wr_ctl_q  <= wr_ctl_sel;
      rx_irq    <= ~empty;

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + PTR_ONE;
        if (pop)     rptr <= rptr + PTR_ONE;
        if (push_ok && !pop)      count <= count + CNT_ONE;
        else if (pop && !push_ok) count <= count - CNT_ONE;
      end

      // A set in the same cycle as a clear wins.
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      if (rd_data_sel)      data_out <= empty ? 8'h00 : mem[rptr];
      else if (rd_stat_sel) data_out <= status;
      else                  data_out <= 8'h00;
    end
  end

endmodule
